// File: rtl/eth_hdr_rx_filter.sv
// -----------------------------------------------------------------------------
// eth_hdr_rx_filter
// Strips the 14-byte Ethernet header from an AXI-Stream byte stream, presents
// the parsed header on a separate valid/ready handshake, forwards the payload
// with zero latency, and discards frames whose destination MAC is neither the
// station address nor (optionally) broadcast.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axis_*                   input byte stream (tdata/tvalid/tready/tlast/tuser)
//   m_hdr_valid/m_hdr_ready    header handshake
//   m_hdr_dest_mac/src_mac/type parsed header fields, first wire byte is MSB
//   m_payload_axis_*           payload byte stream, header removed
//   err_short_frame            one-cycle pulse: frame ended inside the header
//   drop_count                 saturating count of address-filtered frames
// -----------------------------------------------------------------------------
module eth_hdr_rx_filter #(
  parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
  parameter int          ACCEPT_BCAST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_hdr_valid,
  input  logic        m_hdr_ready,
  output logic [47:0] m_hdr_dest_mac,
  output logic [47:0] m_hdr_src_mac,
  output logic [15:0] m_hdr_type,
  output logic [7:0]  m_payload_axis_tdata,
  output logic        m_payload_axis_tvalid,
  input  logic        m_payload_axis_tready,
  output logic        m_payload_axis_tlast,
  output logic        m_payload_axis_tuser,
  output logic        err_short_frame,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {HDR, HDR_OUT, PAYLOAD, DROP} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_cnt;
  logic [3:0]     w_cnt_nxt;
  logic [111:0]   r_hdr;
  logic [15:0]    r_drop_cnt;
  logic           r_err;
  logic           w_err_nxt;
  logic           w_drop_inc;
  logic           r_run;
  logic           w_tready;
  logic           w_hs;
  logic [47:0]    w_dest_early;
  logic           w_match;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Before the byte-13 shift, bytes 0..12 occupy r_hdr[103:0], so the
  // destination address sits at [103:56] on the cycle the decision is made.
  assign w_dest_early = r_hdr[103:56];
  assign w_match      = (w_dest_early == LOCAL_MAC) ||
                        ((ACCEPT_BCAST != 0) && (w_dest_early == 48'hFFFF_FFFF_FFFF));

  // Ready depends only on registered state and the downstream ready, which
  // keeps the handshake free of combinational loops. r_run holds ready low
  // for as long as reset is asserted.
  always_comb begin
    w_tready = 1'b0;
    case (r_state)
      HDR:     w_tready = r_run;
      HDR_OUT: w_tready = 1'b0;
      PAYLOAD: w_tready = m_payload_axis_tready;
      DROP:    w_tready = r_run;
      default: w_tready = 1'b0;
    endcase
  end

  assign w_hs = s_axis_tvalid && w_tready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    w_drop_inc  = 1'b0;
    case (r_state)
      HDR: begin
        if (w_hs) begin
          if (s_axis_tlast) begin
            w_cnt_nxt = 4'd0;
            w_err_nxt = 1'b1;
          end else if (r_cnt == 4'd13) begin
            w_cnt_nxt = 4'd0;
            if (w_match) begin
              w_state_nxt = HDR_OUT;
            end else begin
              w_state_nxt = DROP;
              w_drop_inc  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      HDR_OUT: begin
        if (m_hdr_ready) w_state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        if (w_hs && s_axis_tlast) begin
          w_state_nxt = HDR;
          w_cnt_nxt   = 4'd0;
        end
      end
      DROP: begin
        if (w_hs && s_axis_tlast) begin
          w_state_nxt = HDR;
          w_cnt_nxt   = 4'd0;
        end
      end
      default: w_state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HDR;
      r_cnt      <= 4'd0;
      r_hdr      <= '0;
      r_drop_cnt <= 16'd0;
      r_err      <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_run   <= 1'b1;
      if ((r_state == HDR) && w_hs) r_hdr <= {r_hdr[103:0], s_axis_tdata};
      if (w_drop_inc) r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign s_axis_tready         = w_tready;
  assign m_hdr_valid           = (r_state == HDR_OUT);
  assign m_hdr_dest_mac        = r_hdr[111:64];
  assign m_hdr_src_mac         = r_hdr[63:16];
  assign m_hdr_type            = r_hdr[15:0];
  assign m_payload_axis_tdata  = s_axis_tdata;
  assign m_payload_axis_tvalid = (r_state == PAYLOAD) && s_axis_tvalid;
  assign m_payload_axis_tlast  = s_axis_tlast;
  assign m_payload_axis_tuser  = s_axis_tuser;
  assign err_short_frame       = r_err;
  assign drop_count            = r_drop_cnt;

endmodule

// File: doc/eth_hdr_rx_filter.md
ETH_HDR_RX_FILTER -- requirements
Module: eth_hdr_rx_filter

Interface
REQ-001 The block SHALL have parameter LOCAL_MAC, default 48'h02_00_00_00_00_01, which is the station MAC address accepted as destination.
REQ-002 The block SHALL have parameter ACCEPT_BCAST, default 1, which when 1 also accepts destination FF:FF:FF:FF:FF:FF.
REQ-003 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Ports s_axis_tdata/tvalid/tready/tlast/tuser, in/in/out/in/in, 8/1/1/1/1, the byte stream from the MAC RX FIFO.
REQ-006 Ports m_hdr_valid/m_hdr_ready, out/in, 1/1, the header handshake.
REQ-007 Ports m_hdr_dest_mac, m_hdr_src_mac, m_hdr_type, outputs, 48/48/16, the parsed header fields; the first byte on the wire is the MSB.
REQ-008 Ports m_payload_axis_tdata/tvalid/tready/tlast/tuser, out/out/in/out/out, 8/1/1/1/1, the payload stream with the header stripped.
REQ-009 Port err_short_frame, output, 1, a one-cycle pulse when a frame ends at or before header byte 13.
REQ-010 Port drop_count, output, 16, a saturating count of frames discarded by the address filter.

Function
REQ-011 The block SHALL have four states: HDR, HDR_OUT, PAYLOAD and DROP. Reset state is HDR.
REQ-012 In HDR:
- s_axis_tready=1.
- Each accepted byte is shifted into the header registers.
- A 4-bit byte counter runs 0..13.
REQ-013 In HDR, a handshake with tlast=1 at counter 0..13 SHALL:
- pulse err_short_frame for one cycle;
- clear the counter and stay in HDR;
- produce no header or payload output.
REQ-014 On the byte-13 handshake with tlast=0, the block SHALL test dest_mac. It matches if dest_mac==LOCAL_MAC, or if ACCEPT_BCAST=1 and dest_mac is all ones.
- Match: go to HDR_OUT.
- No match: go to DROP and increment drop_count, saturating at 16'hFFFF.
REQ-015 In HDR_OUT:
- m_hdr_valid=1 with the fields held stable;
- s_axis_tready=0;
- on m_hdr_valid&&m_hdr_ready, go to PAYLOAD the next cycle.
REQ-016 In PAYLOAD, the payload path SHALL be combinational with zero latency:
- m_payload tdata/tvalid/tlast/tuser equal the s_axis signals;
- s_axis_tready=m_payload_axis_tready.
REQ-017 In PAYLOAD, a handshake with tlast=1 SHALL return the block to HDR with the counter cleared.
REQ-018 In DROP:
- s_axis_tready=1 and m_payload_axis_tvalid=0;
- a handshake with tlast=1 returns the block to HDR.
REQ-019 Outside PAYLOAD, m_payload_axis_tvalid SHALL be 0. Outside HDR_OUT, m_hdr_valid SHALL be 0.
REQ-020 tuser SHALL be ignored in HDR and DROP. In PAYLOAD it is forwarded unchanged, so bad-frame marking reaches the consumer.
REQ-021 Back-to-back frames SHALL be accepted with no idle cycle: the byte after a tlast handshake is header byte 0.
REQ-022 s_axis_tvalid=0 at any point SHALL stall the state and the counter without loss of data.
REQ-023 drop_count SHALL never wrap. err_short_frame SHALL never be asserted for two consecutive cycles from a single frame.

Reset
REQ-024 While rst_n=0, asynchronously:
- state=HDR, counter=0;
- all header registers=0;
- drop_count=0;
- m_hdr_valid=0, m_payload_axis_tvalid=0, err_short_frame=0.
REQ-025 While rst_n=0, s_axis_tready SHALL be 0.
REQ-026 After rst_n deasserts mid-frame, the next accepted byte SHALL be treated as header byte 0; the block does not resynchronize to frame boundaries.

Verification
REQ-027 Unicast frame:
- Stimulus: dest=LOCAL_MAC, src=00:11:22:33:44:55, type=0800, payload 01..0A with tlast on 0A; m_hdr_ready=1 and payload ready=1.
- Response: one m_hdr_valid pulse with these fields, then exactly 10 payload bytes 01..0A with tlast on 0A; drop_count=0.
REQ-028 Broadcast and foreign frames:
- Broadcast with ACCEPT_BCAST=1 -> accepted.
- dest=02:00:00:00:00:02 -> zero payload beats, drop_count=1.
- The same broadcast with ACCEPT_BCAST=0 -> dropped.
REQ-029 Short frame: 10-byte frame with tlast on byte 9 -> one err_short_frame pulse, no m_hdr_valid; a following valid frame is parsed correctly.
REQ-030 Backpressure:
- m_hdr_ready held 0 for 5 cycles -> s_axis_tready=0 for those cycles and the header fields are stable.
- Random payload tready/tvalid gaps -> payload bytes arrive intact and in order.
REQ-031 Reset and saturation:
- rst_n pulsed low during PAYLOAD -> outputs reach their reset values immediately; the next frame is parsed from byte 0.
- 65537 foreign frames -> drop_count=16'hFFFF.
